// File: rtl/bitsplit_serializer.sv
// -----------------------------------------------------------------------------
// bitsplit_serializer
//   Upstream feeder for a bit-serial bubble-sort row. Collects NUM_WORDS words
//   over a valid/ready handshake, then replays them as NUM_WORDS parallel bit
//   lanes, MSB first, for WIDTH cycles framed by run_o. Each frame ends with
//   GAP_CYCLES idle cycles (run_o low) so downstream cells clear their state.
//
//   Phase lengths: LOAD >= NUM_WORDS, SHIFT = WIDTH, GAP = GAP_CYCLES cycles.
//   run_o is high for the whole SHIFT phase. Lane 0 shows the MSB of word 0
//   in the first cycle after the final accept edge.
//
// Optional feature macro: BITSPLIT_SER_SIGNED_EN
//   defined     : MSB of each word is inverted at bank write, so two's-complement
//                 values sort correctly through unsigned compare cells
//   not defined : words are stored and shifted unmodified
//
// Ports
//   clk           in   1          clock, rising edge
//   rst_n         in   1          synchronous active-low reset
//   s_valid_i     in   1          input word valid
//   s_ready_o     out  1          high in LOAD; word taken on valid & ready
//   s_data_i      in   WIDTH      input word, arrival order k -> lane k
//   bits_o        out  NUM_WORDS  current bit of every lane
//   run_o         out  1          high for exactly WIDTH cycles per frame
//   swap_o        out  1          swap-chain seed for the first cell (always 0)
//   busy_o        out  1          high in SHIFT and GAP
//   frame_done_o  out  1          one-cycle pulse on the last GAP cycle
// -----------------------------------------------------------------------------
module bitsplit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_WORDS  = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [WIDTH-1:0]     s_data_i,
    output logic [NUM_WORDS-1:0] bits_o,
    output logic                 run_o,
    output logic                 swap_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);

    // Counter widths; kept at least one bit so WIDTH==1 still elaborates
    localparam int unsigned WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GCW = $clog2(GAP_CYCLES + 1);

    localparam logic [WCW-1:0] WR_LAST  = WCW'(NUM_WORDS - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);

    // Elaboration-time parameter sanity
    if (WIDTH < 1) begin : g_bad_width
        $error("bitsplit_serializer: WIDTH must be >= 1");
    end
    if (NUM_WORDS < 2) begin : g_bad_words
        $error("bitsplit_serializer: NUM_WORDS must be >= 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("bitsplit_serializer: GAP_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WCW-1:0]         r_wr_cnt;
    logic [BCW-1:0]         r_bit_cnt;
    logic [GCW-1:0]         r_gap_cnt;
    logic [WIDTH-1:0]       r_bank [NUM_WORDS];
    logic                   r_s_ready;
    logic [NUM_WORDS-1:0]   r_bits;
    logic                   r_run;
    logic                   r_busy;
    logic                   r_frame_done;

    logic                   w_hs;
    logic [WIDTH-1:0]       w_word;
    logic [WIDTH-1:0]       w_first [NUM_WORDS];

    assign w_hs = s_valid_i & r_s_ready;

    // Word as stored in the bank (optionally offset-binary for signed order)
    always_comb begin
        w_word = s_data_i;
`ifdef BITSPLIT_SER_SIGNED_EN
        w_word[WIDTH-1] = ~s_data_i[WIDTH-1];
`endif
    end

    // Bank view at the final accept edge: last lane comes straight from the input
    always_comb begin
        for (int k = 0; k < NUM_WORDS; k++) begin
            w_first[k] = r_bank[k];
        end
        w_first[NUM_WORDS-1] = w_word;
    end

    // Control FSM with registered outputs. The bank doubles as the per-lane
    // shift register, so it is empty again once a frame has been shifted out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_LOAD;
            r_wr_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            for (int k = 0; k < NUM_WORDS; k++) begin
                r_bank[k] <= '0;
            end
            r_s_ready    <= 1'b1;
            r_bits       <= '0;
            r_run        <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_hs) begin
                        if (r_wr_cnt == WR_LAST) begin
                            // Final word: present every lane's MSB right away
                            r_state   <= ST_SHIFT;
                            r_wr_cnt  <= '0;
                            r_bit_cnt <= '0;
                            r_s_ready <= 1'b0;
                            r_busy    <= 1'b1;
                            r_run     <= 1'b1;
                            for (int k = 0; k < NUM_WORDS; k++) begin
                                r_bits[k] <= w_first[k][WIDTH-1];
                                r_bank[k] <= w_first[k] << 1;
                            end
                        end else begin
                            r_bank[r_wr_cnt] <= w_word;
                            r_wr_cnt         <= r_wr_cnt + WCW'(1);
                        end
                    end
                end

                ST_SHIFT: begin
                    if (r_bit_cnt == BIT_LAST) begin
                        r_state      <= ST_GAP;
                        r_bit_cnt    <= '0;
                        r_gap_cnt    <= '0;
                        r_run        <= 1'b0;
                        r_bits       <= '0;
                        r_frame_done <= (GAP_CYCLES == 1);
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                        for (int k = 0; k < NUM_WORDS; k++) begin
                            r_bits[k] <= r_bank[k][WIDTH-1];
                            r_bank[k] <= r_bank[k] << 1;
                        end
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state      <= ST_LOAD;
                        r_gap_cnt    <= '0;
                        r_frame_done <= 1'b0;
                        r_s_ready    <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_gap_cnt    <= r_gap_cnt + GCW'(1);
                        // Raise the pulse so it lands on the last GAP cycle
                        r_frame_done <= ((r_gap_cnt + GCW'(1)) == GAP_LAST);
                    end
                end

                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign s_ready_o    = r_s_ready;
    assign bits_o       = r_bits;
    assign run_o        = r_run;
    assign busy_o       = r_busy;
    assign frame_done_o = r_frame_done;
    // First cell never receives a pending swap from upstream
    assign swap_o       = 1'b0;

endmodule

// File: tb/tb_bitsplit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bitsplit_serializer
//   Directed bench for bitsplit_serializer (WIDTH=8, NUM_WORDS=4). Instance u1
//   uses GAP_CYCLES=1, instance u3 uses GAP_CYCLES=3; a select bit routes the
//   shared stimulus/observation tasks to one of them.
// -----------------------------------------------------------------------------
module tb_bitsplit_serializer;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel3;
    logic         tv;
    logic [W-1:0] td;

    logic         v1, v3;
    logic         rdy1, rdy3, run1, run3, swp1, swp3, bsy1, bsy3, fd1, fd3;
    logic [N-1:0] bits1, bits3;

    logic         m_ready, m_run, m_swap, m_busy, m_fd;
    logic [N-1:0] m_bits;

    int vectors     = 0;
    int miscompares = 0;
    int hs1         = 0;

    always #5 clk = ~clk;

    assign v1 = tv & ~sel3;
    assign v3 = tv & sel3;

    assign m_ready = sel3 ? rdy3  : rdy1;
    assign m_run   = sel3 ? run3  : run1;
    assign m_swap  = sel3 ? swp3  : swp1;
    assign m_busy  = sel3 ? bsy3  : bsy1;
    assign m_fd    = sel3 ? fd3   : fd1;
    assign m_bits  = sel3 ? bits3 : bits1;

    bitsplit_serializer #(.WIDTH(W), .NUM_WORDS(N), .GAP_CYCLES(1)) u1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid_i    (v1),
        .s_ready_o    (rdy1),
        .s_data_i     (td),
        .bits_o       (bits1),
        .run_o        (run1),
        .swap_o       (swp1),
        .busy_o       (bsy1),
        .frame_done_o (fd1)
    );

    bitsplit_serializer #(.WIDTH(W), .NUM_WORDS(N), .GAP_CYCLES(3)) u3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid_i    (v3),
        .s_ready_o    (rdy3),
        .s_data_i     (td),
        .bits_o       (bits3),
        .run_o        (run3),
        .swap_o       (swp3),
        .busy_o       (bsy3),
        .frame_done_o (fd3)
    );

    // Handshakes accepted by u1
    always @(posedge clk) begin
        if (rst_n && v1 && rdy1) hs1 <= hs1 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(m_ready), 32'd1);
        chk({tag, "_bits"},  32'(m_bits),  32'd0);
        chk({tag, "_run"},   32'(m_run),   32'd0);
        chk({tag, "_swap"},  32'(m_swap),  32'd0);
        chk({tag, "_busy"},  32'(m_busy),  32'd0);
        chk({tag, "_fd"},    32'(m_fd),    32'd0);
    endtask

    // Offer one word, waiting (bounded) for ready; returns one cycle after the accept edge
    task automatic send(input string tag, input logic [W-1:0] d);
        for (int i = 0; i < 20 && m_ready !== 1'b1; i++) tick();
        chk({tag, "_ready_wait"}, 32'(m_ready), 32'd1);
        tv = 1'b1;
        td = d;
        tick();
        tv = 1'b0;
        td = 8'h00;
    endtask

    // Called at the first SHIFT cycle; exp holds lane nibbles, cycle j at exp[4*j+:4]
    task automatic check_frame(input string tag, input logic [31:0] exp, input int gap,
                               input bit hold_valid);
        for (int j = 0; j < W; j++) begin
            chk($sformatf("%s_run_j%0d", tag, j),   32'(m_run),   32'd1);
            chk($sformatf("%s_bits_j%0d", tag, j),  32'(m_bits),  32'(exp[4*j +: 4]));
            chk($sformatf("%s_busy_j%0d", tag, j),  32'(m_busy),  32'd1);
            chk($sformatf("%s_ready_j%0d", tag, j), 32'(m_ready), 32'd0);
            chk($sformatf("%s_swap_j%0d", tag, j),  32'(m_swap),  32'd0);
            if (hold_valid) begin
                tv = 1'b1;
                td = 8'hEE;
            end
            tick();
        end
        tv = 1'b0;
        for (int g = 0; g < gap; g++) begin
            chk($sformatf("%s_gap_run_g%0d", tag, g),   32'(m_run),   32'd0);
            chk($sformatf("%s_gap_bits_g%0d", tag, g),  32'(m_bits),  32'd0);
            chk($sformatf("%s_gap_busy_g%0d", tag, g),  32'(m_busy),  32'd1);
            chk($sformatf("%s_gap_ready_g%0d", tag, g), 32'(m_ready), 32'd0);
            chk($sformatf("%s_gap_fd_g%0d", tag, g),    32'(m_fd),    32'((g == gap - 1) ? 1 : 0));
            tick();
        end
        chk({tag, "_end_ready"}, 32'(m_ready), 32'd1);
        chk({tag, "_end_busy"},  32'(m_busy),  32'd0);
        chk({tag, "_end_fd"},    32'(m_fd),    32'd0);
        chk({tag, "_end_run"},   32'(m_run),   32'd0);
    endtask

    initial begin
        logic [31:0] exp_signed;
        int          hs_before;

        rst_n = 1'b0;
        sel3  = 1'b0;
        tv    = 1'b0;
        td    = '0;

        // Reset and idle: no frame without data
        tick();
        tick();
        rst_n = 1'b1;
        chk_reset_vals("t1_reset");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t1_idle_run_%0d", i), 32'(m_run), 32'd0);
        end
        chk("t1_idle_ready", 32'(m_ready), 32'd1);

        // Back-to-back load of A5,3C,FF,00
        send("t2_w0", 8'hA5);
        send("t2_w1", 8'h3C);
        send("t2_w2", 8'hFF);
        send("t2_w3", 8'h00);
        check_frame("t2", 32'h54766745, 1, 1'b0);

        // Bubbled valid during load, valid held during SHIFT
        hs_before = hs1;
        send("t3_w0", 8'h81);
        tick();
        send("t3_w1", 8'h42);
        tick();
        tick();
        send("t3_w2", 8'h24);
        tick();
        send("t3_w3", 8'h18);
        check_frame("t3", 32'h12488421, 1, 1'b1);
        chk("t3_hs_count", 32'(hs1 - hs_before), 32'd4);

        // Reset during SHIFT cycle 4, then a clean reload
        send("t5_w0", 8'hFF);
        send("t5_w1", 8'hFF);
        send("t5_w2", 8'hFF);
        send("t5_w3", 8'hFF);
        for (int i = 0; i < 4; i++) tick();
        chk("t5_pre_run", 32'(m_run), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_vals("t5_reset");
        send("t5_r0", 8'h01);
        send("t5_r1", 8'h02);
        send("t5_r2", 8'h04);
        send("t5_r3", 8'h08);
        check_frame("t5", 32'h12480000, 1, 1'b0);

        // MSB handling: 0x80, 0x7F, 0x00, 0xFF
`ifdef BITSPLIT_SER_SIGNED_EN
        exp_signed = 32'hAAAAAAA6;
`else
        exp_signed = 32'hAAAAAAA9;
`endif
        send("t6_w0", 8'h80);
        send("t6_w1", 8'h7F);
        send("t6_w2", 8'h00);
        send("t6_w3", 8'hFF);
        check_frame("t6", exp_signed, 1, 1'b0);

        // GAP_CYCLES=3 instance, two frames back-to-back
        sel3 = 1'b1;
        #1;
        chk_reset_vals("t4_idle");
        send("t4a_w0", 8'h11);
        send("t4a_w1", 8'h22);
        send("t4a_w2", 8'h33);
        send("t4a_w3", 8'h44);
        check_frame("t4a", 32'h56805680, 3, 1'b0);
        send("t4b_w0", 8'hF0);
        send("t4b_w1", 8'h0F);
        send("t4b_w2", 8'hC3);
        send("t4b_w3", 8'h3C);
        check_frame("t4b", 32'h66AA9955, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
